// File: rtl/cordic_vec_arb.sv
// Round-robin front end sharing one pipelined CORDIC vectoring engine among NREQ requesters.
// Credits bound the work in flight, so every returning angle always finds a free slot in the result FIFO.
module cordic_vec_arb #(
    parameter int NREQ  = 4,
    parameter int W     = 32,
    parameter int LAT   = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_x,
    input  logic [NREQ*W-1:0]        req_y,
    output logic                     eng_valid,
    output logic [W-1:0]             eng_x,
    output logic [W-1:0]             eng_y,
    input  logic [W-1:0]             eng_angle,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [W-1:0]             res_angle,
    input  logic                     res_ready,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0] ptr_reg;
    logic [CW-1:0]  credit_reg;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_id;
    logic           accept;
    logic           pop;
    int             idx;

    // Scan ptr, ptr+1, ... modulo NREQ and grant the first valid requester.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        accept   = 1'b0;
        idx      = 0;
        if (rst_n && credit_reg != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_reg) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!accept && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = IDW'(idx);
                    accept     = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (accept) begin
            ptr_reg <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_reg <= CW'(DEPTH);
        end else if (accept && !pop) begin
            credit_reg <= credit_reg - 1'b1;
        end else if (pop && !accept) begin
            credit_reg <= credit_reg + 1'b1;
        end
    end

    assign busy = (credit_reg != CW'(DEPTH));

    logic           eng_valid_reg;
    logic [W-1:0]   eng_x_reg;
    logic [W-1:0]   eng_y_reg;
    logic [IDW-1:0] eng_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid_reg <= 1'b0;
            eng_x_reg     <= '0;
            eng_y_reg     <= '0;
            eng_id_reg    <= '0;
        end else begin
            eng_valid_reg <= accept;
            if (accept) begin
                eng_x_reg  <= req_x[grant_id*W +: W];
                eng_y_reg  <= req_y[grant_id*W +: W];
                eng_id_reg <= grant_id;
            end
        end
    end

    assign eng_valid = eng_valid_reg;
    assign eng_x     = eng_x_reg;
    assign eng_y     = eng_y_reg;

    // Tag stage 0 captures the issue cycle, so the last stage lines up with eng_angle.
    logic [LAT-1:0] tag_v_reg;
    logic [IDW-1:0] tag_id_reg [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_reg[0]  <= 1'b0;
            tag_id_reg[0] <= '0;
        end else begin
            tag_v_reg[0]  <= eng_valid_reg;
            tag_id_reg[0] <= eng_id_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_v_reg[gi]  <= 1'b0;
                    tag_id_reg[gi] <= '0;
                end else begin
                    tag_v_reg[gi]  <= tag_v_reg[gi-1];
                    tag_id_reg[gi] <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    logic push;
    assign push = tag_v_reg[LAT-1];

    logic [IDW-1:0] fifo_id_mem  [DEPTH];
    logic [W-1:0]   fifo_ang_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_mem[wr_ptr_reg]  <= tag_id_reg[LAT-1];
            fifo_ang_mem[wr_ptr_reg] <= eng_angle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (int'(wr_ptr_reg) == DEPTH - 1) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (int'(rd_ptr_reg) == DEPTH - 1) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Head fields read as zero while empty so stale RAM contents never show.
    assign res_valid = (count_reg != '0);
    assign res_id    = res_valid ? fifo_id_mem[rd_ptr_reg]  : '0;
    assign res_angle = res_valid ? fifo_ang_mem[rd_ptr_reg] : '0;
    assign pop       = res_valid & res_ready;

endmodule

// File: tb/tb_cordic_vec_arb.sv
// Scoreboard bench: expected {id, angle, due cycle} queued on accept, compared when the FIFO head pops.
module tb_cordic_vec_arb;
    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int LAT   = 18;
    localparam int DEPTH = 8;
    localparam int IDW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_x;
    logic [NREQ*W-1:0]    req_y;
    logic                 eng_valid;
    logic [W-1:0]         eng_x;
    logic [W-1:0]         eng_y;
    logic [W-1:0]         eng_angle;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [W-1:0]         res_angle;
    logic                 res_ready;
    logic                 busy;

    cordic_vec_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .eng_valid(eng_valid), .eng_x(eng_x), .eng_y(eng_y), .eng_angle(eng_angle),
        .res_valid(res_valid), .res_id(res_id), .res_angle(res_angle),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] angle;
        int           due;
    } sb_entry_t;

    sb_entry_t    sb[$];
    int           n_cmp = 0;
    int           n_mis = 0;
    int           cyc   = 0;
    int           n_acc = 0;
    int           rem [NREQ];
    int           ox  [NREQ];
    int           oy  [NREQ];
    int           ptr_m;
    int           credit_m;
    logic         exp_ev;
    logic [W-1:0] exp_x;
    logic [W-1:0] exp_y;
    logic [W-1:0] pipe [LAT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_angle(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
        return W'($rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)));
    endfunction

    task automatic new_operands(input int i);
        ox[i] = int'($urandom_range(0, 2000)) - 1000;
        oy[i] = int'($urandom_range(0, 2000)) - 1000;
        if (ox[i] == 0 && oy[i] == 0) ox[i] = 1;
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]     = (rem[i] > 0);
            req_x[i*W +: W]  = W'(ox[i]);
            req_y[i*W +: W]  = W'(oy[i]);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        ptr_m    = 0;
        credit_m = DEPTH;
        exp_ev   = 1'b0;
        exp_x    = '0;
        exp_y    = '0;
    endtask

    // One clock: check every output mid-cycle, update the model, then advance engine and drivers.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        logic            ev_s;
        logic [W-1:0]    ex_s;
        logic [W-1:0]    ey_s;
        int              g;
        sb_entry_t       e;
        @(negedge clk);
        exp_rdy = '0;
        g = -1;
        if (rst_n && credit_m > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int ix;
                ix = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[ix]) g = ix;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("eng_valid", 64'(eng_valid), 64'(exp_ev));
        check("eng_x", 64'(eng_x), 64'(exp_x));
        check("eng_y", 64'(eng_y), 64'(exp_y));
        exp_rv = (sb.size() > 0) && (sb[0].due <= cyc);
        check("res_valid", 64'(res_valid), 64'(exp_rv));
        check("busy", 64'(busy), 64'(credit_m != DEPTH));
        if (exp_rv && res_ready) begin
            e = sb.pop_front();
            check("res_id", 64'(res_id), 64'(e.id));
            check("res_angle", 64'(res_angle), 64'(e.angle));
            credit_m++;
        end
        ev_s = eng_valid;
        ex_s = eng_x;
        ey_s = eng_y;
        exp_ev = (g >= 0);
        if (g >= 0) begin
            e.id    = g;
            e.angle = ref_angle(ox[g], oy[g]);
            e.due   = cyc + 2 + LAT;
            sb.push_back(e);
            credit_m--;
            ptr_m = (g + 1) % NREQ;
            exp_x = W'(ox[g]);
            exp_y = W'(oy[g]);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0]   = ev_s ? ref_angle(int'($signed(ex_s)), int'($signed(ey_s))) : W'($urandom);
        eng_angle = pipe[LAT-1];
        if (g >= 0) begin
            rem[g]--;
            new_operands(g);
        end
        apply();
    endtask

    task automatic drain();
        int n;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        apply();
        res_ready = 1'b1;
        n = 0;
        while ((busy || sb.size() > 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_busy", 64'(busy), 64'(0));
        check("drain_sb", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int c0;
        int n;
        rst_n     = 1'b0;
        res_ready = 1'b0;
        eng_angle = '0;
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            new_operands(i);
        end
        apply();
        model_reset();
        step();
        step();
        rst_n = 1'b1;

        // Single request from requester 2: 45 degrees, first res_valid 20 cycles after accept.
        ox[2] = 100;
        oy[2] = 100;
        rem[2] = 1;
        apply();
        res_ready = 1'b1;
        c0 = cyc;
        n = 0;
        step();
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        check("single_latency", 64'(cyc - c0), 64'(20));
        check("single_id", 64'(res_id), 64'(2));
        check("single_angle", 64'(res_angle), 64'(45));
        drain();

        // All requesters continuously valid.
        for (int i = 0; i < NREQ; i++) rem[i] = 12;
        apply();
        for (int k = 0; k < 60; k++) step();
        drain();

        // Only requesters 1 and 3.
        rem[1] = 10;
        rem[3] = 10;
        apply();
        for (int k = 0; k < 50; k++) step();
        drain();

        // Backpressure: credits cap accepts at DEPTH, a single pop frees exactly one more.
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        apply();
        c0 = n_acc;
        for (int k = 0; k < 30; k++) step();
        check("bp_accepts", 64'(n_acc - c0), 64'(DEPTH));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("bp_one_more", 64'(n_acc - c0), 64'(DEPTH + 1));

        // Continuous push and pop at full occupancy.
        res_ready = 1'b1;
        for (int k = 0; k < 60; k++) step();
        drain();

        // Reset while three operations are in flight.
        rem[0] = 1;
        rem[1] = 1;
        rem[2] = 1;
        apply();
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        apply();
        model_reset();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_res_valid", 64'(res_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
